multdiv_sequencer: RTL and testbench
====================================

# multdiv_sequencer

Multi-cycle signed multiply/divide controller that time-shares one external 32-bit add/sub unit (opcode `00000` add, `00001` subtract). The block holds the operand, accumulator and quotient registers and a state machine. Each cycle it drives one add/sub request to the shared unit and captures the sum in the same cycle. It sits beside the single-cycle ALU in the execute stage and serves mult/div instructions.

## Interface
Parameters:
- `ITERS`, 32: iteration count (equals operand width; only 32 supported)

Ports:
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `data_operandA`  in  32  multiplicand / dividend, sampled at start
- `data_operandB`  in  32  multiplier / divisor, sampled at start
- `ctrl_MULT`  in  1  start multiply (pulse)
- `ctrl_DIV`  in  1  start divide (pulse)
- `data_result`  out  32  product low word / quotient
- `data_exception`  out  1  overflow or divide-by-zero
- `data_resultRDY`  out  1  one-cycle completion pulse
- `busy`  out  1  operation in flight
- `alu_operandA`, `alu_operandB`  out  32  requests to the shared add/sub unit
- `alu_opcode`  out  5  `00000` add / `00001` sub
- `alu_result`  in  32  combinational sum from the unit
- `alu_overflow`  in  1  signed overflow from the unit

## Operation
- States: IDLE, MUL_ITER, DIV_ABS_A, DIV_ABS_B, DIV_ITER, DIV_SIGN, DONE.
- Start rules:
  - A start is accepted only when `busy`=0 (IDLE or DONE).
  - `ctrl_MULT` has priority if both starts are high.
  - Starts seen while `busy`=1 are ignored.
  - Operands are latched in the accept cycle.
- Multiply (Booth radix-2):
  - Registers: A (upper, reset to 0), Q = operandB, q₋₁ = 0, M = operandA.
  - Each MUL_ITER cycle, {Q[0], q₋₁} selects the operation: 01 gives A+M, 10 gives A−M, 00/11 give A+0.
  - The 65-bit {A,Q,q₋₁} is then shifted right arithmetically. The shifted-in sign is `alu_result[31] ^ alu_overflow`, which makes M = 0x80000000 correct.
  - Result = Q.
  - Exception = A ≠ {32{Q[31]}}.
- Divide (restoring, on magnitudes):
  - DIV_ABS_A: the ALU computes 0−A if A<0; otherwise A passes through.
  - DIV_ABS_B: same step for B.
  - DIV_ITER: R' = {R[30:0], dividend MSB}; the ALU computes R' − D. The compare is unsigned: ge = (R'[31]==D[31]) ? ~alu_result[31] : R'[31]. If ge, R ← alu_result and the quotient bit is 1; otherwise R ← R' and the quotient bit is 0.
  - DIV_SIGN: the ALU computes 0−Q when the operand signs differ. The quotient truncates toward zero; the remainder is discarded.
  - Exception, with result forced to 0: divisor = 0, or (0x80000000 ÷ 0xFFFFFFFF).
- In IDLE/DONE the ALU ports drive 0/0/`00000`.

## Timing
- Accept in cycle t:
  - MULT: MUL_ITER t+1..t+32, DONE and `data_resultRDY`=1 at t+33.
  - DIV: ABS t+1,t+2; ITER t+3..t+34; SIGN t+35; DONE at t+36.
- Latency is fixed regardless of data or exception.
- Timing of `busy`:
  - `busy`=1 from t+1 through the last cycle before DONE.
  - `busy`=0 in DONE, so a back-to-back start may be accepted in the RDY cycle.
- `data_result` and `data_exception` update on entry to DONE and hold until the next completion.
- Reset values, asynchronous: state IDLE, all registers 0, `data_result`=0, `data_exception`=0, `data_resultRDY`=0, `busy`=0.
- Reset mid-operation aborts with no RDY pulse.
- Iteration counter: 0..ITERS−1; the transition occurs when count == ITERS−1.

## Structure
- Package `multdiv_pkg`:
  - state enum
  - `ALU_ADD` = 5'b00000, `ALU_SUB` = 5'b00001
  - `ITERS_DEFAULT` = 32
  - `INT_MIN` = 32'h8000_0000
- Sub-module `multdiv_counter`: a 5-bit iteration counter with clear, enable and a `last` flag.
- The FSM and datapath registers stay in the top module.

## Test plan
- MULT 7 × −3 (0xFFFFFFFD) → result 0xFFFFFFEB, exception 0, RDY exactly at t+33, `busy` high t+1..t+32.
- MULT 0x00010000 × 0x00010000 → result 0x00000000, exception 1. MULT 0x80000000 × 1 → 0x80000000, exception 0.
- DIV −7 ÷ 2 → 0xFFFFFFFD, exception 0, RDY at t+36. DIV 100 ÷ 7 → 0x0000000E.
- DIV 5 ÷ 0 → result 0, exception 1. DIV 0x80000000 ÷ 0xFFFFFFFF → result 0, exception 1. DIV 0x80000000 ÷ 2 → 0xC0000000.
- Assert `ctrl_DIV` at t+5 of a MULT → ignored, MULT completes unchanged. Assert `ctrl_MULT` in the DONE cycle → accepted, next RDY 33 cycles later.
- Assert `reset` asynchronously at t+10 of a DIV → all outputs 0 immediately, no RDY. A following MULT 3 × 4 → 12.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide sequencer.
package multdiv_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MUL_ITER  = 3'd1,
    S_DIV_ABS_A = 3'd2,
    S_DIV_ABS_B = 3'd3,
    S_DIV_ITER  = 3'd4,
    S_DIV_SIGN  = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  localparam logic [4:0]  ALU_ADD       = 5'b00000;
  localparam logic [4:0]  ALU_SUB       = 5'b00001;
  localparam int          ITERS_DEFAULT = 32;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

endpackage

// File: rtl/multdiv_counter.sv
// Iteration counter for the multiply/divide loops; clear wins over enable.
module multdiv_counter #(
  parameter logic [4:0] LAST_CNT = 5'd31
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic last
);

  logic [4:0] count;

  // count iterations, restarting whenever a new operation is accepted
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 5'd1;
    end
  end

  // flag the final iteration so the FSM leaves the loop state
  always_comb begin
    last = (count == LAST_CNT);
  end

endmodule

// File: rtl/multdiv_sequencer.sv
// Multi-cycle signed multiply (Booth radix-2) / divide (restoring) controller
// that borrows one external 32-bit add/sub unit each cycle.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | waiting for a start; ALU request parked at 0 + 0
// S_MUL_ITER  | one Booth step per cycle: add/sub M, then arithmetic shift
// S_DIV_ABS_A | dividend magnitude (0 - A when negative)
// S_DIV_ABS_B | divisor magnitude (0 - B when negative)
// S_DIV_ITER  | one restoring step per cycle on magnitudes
// S_DIV_SIGN  | negate quotient when operand signs differ
// S_DONE      | result valid, RDY pulse; a new start may be accepted here
module multdiv_sequencer
  import multdiv_pkg::*;
#(
  parameter int ITERS = ITERS_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy,
  output logic [31:0] alu_operandA,
  output logic [31:0] alu_operandB,
  output logic [4:0]  alu_opcode,
  input  logic [31:0] alu_result,
  input  logic        alu_overflow
);

  localparam logic [4:0] LAST_CNT = 5'(ITERS - 1);

  state_t      state, state_nx;

  // reg_a: Booth upper accumulator / division partial remainder
  // reg_q: multiplier->product low / dividend->quotient
  // reg_m: multiplicand / divisor
  logic [31:0] reg_a, reg_q, reg_m;
  logic        q_m1;
  logic        neg_a, neg_b, exc_pend;

  logic [31:0] a_nx, q_nx, m_nx;
  logic        qm1_nx, neg_a_nx, neg_b_nx, exc_pend_nx;
  logic [31:0] result_nx;
  logic        exception_nx;

  logic        accept;
  logic        cnt_en;
  logic        cnt_last;
  logic        mul_sign;
  logic [31:0] r_sh;
  logic        ge;

  multdiv_counter #(
    .LAST_CNT (LAST_CNT)
  ) u_counter (
    .clock (clock),
    .reset (reset),
    .clr   (accept),
    .en    (cnt_en),
    .last  (cnt_last)
  );

  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next state, ALU request and next datapath values
  always_comb begin
    state_nx     = state;
    accept       = 1'b0;
    alu_operandA = '0;
    alu_operandB = '0;
    alu_opcode   = ALU_ADD;
    a_nx         = reg_a;
    q_nx         = reg_q;
    m_nx         = reg_m;
    qm1_nx       = q_m1;
    neg_a_nx     = neg_a;
    neg_b_nx     = neg_b;
    exc_pend_nx  = exc_pend;
    result_nx    = data_result;
    exception_nx = data_exception;
    mul_sign     = 1'b0;
    r_sh         = '0;
    ge           = 1'b0;

    case (state)
      S_IDLE, S_DONE: begin
        if (ctrl_MULT) begin
          accept   = 1'b1;
          state_nx = S_MUL_ITER;
          a_nx     = '0;
          q_nx     = data_operandB;
          qm1_nx   = 1'b0;
          m_nx     = data_operandA;
        end else if (ctrl_DIV) begin
          accept      = 1'b1;
          state_nx    = S_DIV_ABS_A;
          a_nx        = '0;
          q_nx        = data_operandA;
          qm1_nx      = 1'b0;
          m_nx        = data_operandB;
          neg_a_nx    = data_operandA[31];
          neg_b_nx    = data_operandB[31];
          exc_pend_nx = (data_operandB == '0) ||
                        ((data_operandA == INT_MIN) && (data_operandB == '1));
        end else if (state == S_DONE) begin
          state_nx = S_IDLE;
        end
      end

      S_MUL_ITER: begin
        alu_operandA = reg_a;
        case ({reg_q[0], q_m1})
          2'b01: begin
            alu_operandB = reg_m;
            alu_opcode   = ALU_ADD;
          end
          2'b10: begin
            alu_operandB = reg_m;
            alu_opcode   = ALU_SUB;
          end
          default: begin
            alu_operandB = '0;
            alu_opcode   = ALU_ADD;
          end
        endcase
        // true sign of the 33-bit sum, so M = INT_MIN shifts correctly
        mul_sign = alu_result[31] ^ alu_overflow;
        a_nx     = {mul_sign, alu_result[31:1]};
        q_nx     = {alu_result[0], reg_q[31:1]};
        qm1_nx   = reg_q[0];
        if (cnt_last) begin
          state_nx     = S_DONE;
          result_nx    = q_nx;
          exception_nx = (a_nx != {32{q_nx[31]}});
        end
      end

      S_DIV_ABS_A: begin
        alu_operandB = reg_q;
        alu_opcode   = neg_a ? ALU_SUB : ALU_ADD;
        q_nx         = alu_result;
        state_nx     = S_DIV_ABS_B;
      end

      S_DIV_ABS_B: begin
        alu_operandB = reg_m;
        alu_opcode   = neg_b ? ALU_SUB : ALU_ADD;
        m_nx         = alu_result;
        state_nx     = S_DIV_ITER;
      end

      S_DIV_ITER: begin
        r_sh         = {reg_a[30:0], reg_q[31]};
        alu_operandA = r_sh;
        alu_operandB = reg_m;
        alu_opcode   = ALU_SUB;
        // unsigned r_sh >= reg_m from the signed difference
        ge   = (r_sh[31] == reg_m[31]) ? ~alu_result[31] : r_sh[31];
        a_nx = ge ? alu_result : r_sh;
        q_nx = {reg_q[30:0], ge};
        if (cnt_last) begin
          state_nx = S_DIV_SIGN;
        end
      end

      S_DIV_SIGN: begin
        alu_operandB = reg_q;
        alu_opcode   = (neg_a ^ neg_b) ? ALU_SUB : ALU_ADD;
        q_nx         = alu_result;
        result_nx    = exc_pend ? '0 : alu_result;
        exception_nx = exc_pend;
        state_nx     = S_DONE;
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // datapath and result registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reg_a          <= '0;
      reg_q          <= '0;
      reg_m          <= '0;
      q_m1           <= 1'b0;
      neg_a          <= 1'b0;
      neg_b          <= 1'b0;
      exc_pend       <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else begin
      reg_a          <= a_nx;
      reg_q          <= q_nx;
      reg_m          <= m_nx;
      q_m1           <= qm1_nx;
      neg_a          <= neg_a_nx;
      neg_b          <= neg_b_nx;
      exc_pend       <= exc_pend_nx;
      data_result    <= result_nx;
      data_exception <= exception_nx;
    end
  end

  // status decoded from the state register
  always_comb begin
    cnt_en         = (state == S_MUL_ITER) || (state == S_DIV_ITER);
    data_resultRDY = (state == S_DONE);
    busy           = (state != S_IDLE) && (state != S_DONE);
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer with a behavioural add/sub unit.
module tb_multdiv_sequencer;
  import multdiv_pkg::*;

  logic        clock;
  logic        reset;
  logic [31:0] data_operandA, data_operandB;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;
  logic [31:0] alu_operandA, alu_operandB, alu_result;
  logic [4:0]  alu_opcode;
  logic        alu_overflow;

  int n_cmp = 0;
  int n_err = 0;

  multdiv_sequencer #(.ITERS(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy),
    .alu_operandA   (alu_operandA),
    .alu_operandB   (alu_operandB),
    .alu_opcode     (alu_opcode),
    .alu_result     (alu_result),
    .alu_overflow   (alu_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // shared add/sub unit: opcode 00001 subtracts, anything else adds
  always_comb begin
    if (alu_opcode == ALU_SUB) begin
      alu_result   = alu_operandA - alu_operandB;
      alu_overflow = (alu_operandA[31] != alu_operandB[31]) &&
                     (alu_result[31] != alu_operandA[31]);
    end else begin
      alu_result   = alu_operandA + alu_operandB;
      alu_overflow = (alu_operandA[31] == alu_operandB[31]) &&
                     (alu_result[31] != alu_operandA[31]);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // caller is at a negedge; on return we are at the negedge of cycle t+1
  task automatic issue(input bit is_mult, input logic [31:0] a, input logic [31:0] b);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = is_mult;
    ctrl_DIV      = !is_mult;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
  endtask

  // n_start is the cycle index (relative to accept) of the current negedge
  task automatic wait_done(input int n_start, output int lat, output int busy_bad);
    int n;
    n        = n_start;
    busy_bad = 0;
    while (!data_resultRDY && n < 100) begin
      if (busy !== 1'b1) busy_bad++;
      @(negedge clock);
      n++;
    end
    lat = data_resultRDY ? n : -1;
  endtask

  task automatic finish_checks(input string tag, input int lat, input int busy_bad,
                               input int exp_lat, input logic [31:0] exp_res,
                               input logic exp_exc);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy_run"}, 32'(busy_bad), 32'd0);
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_res"}, data_result, exp_res);
    check({tag, "_exc"}, {31'd0, data_exception}, {31'd0, exp_exc});
  endtask

  task automatic do_op(input string tag, input bit is_mult, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res,
                       input logic exp_exc);
    int lat, bb;
    @(negedge clock);
    issue(is_mult, a, b);
    wait_done(1, lat, bb);
    finish_checks(tag, lat, bb, is_mult ? 33 : 36, exp_res, exp_exc);
  endtask

  initial begin
    int lat, bb, rdy_seen;
    reset         = 1'b1;
    data_operandA = '0;
    data_operandB = '0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    #1;
    check("rst_res", data_result, 32'd0);
    check("rst_flags", {28'd0, data_exception, data_resultRDY, busy, 1'b0}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("idle_alu", alu_operandA | alu_operandB | {27'd0, alu_opcode}, 32'd0);

    do_op("mul_7x-3",    1'b1, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    do_op("mul_ovf",     1'b1, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1);
    do_op("mul_intmin",  1'b1, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0);
    do_op("div_-7/2",    1'b0, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0);
    do_op("div_100/7",   1'b0, 32'd100,        32'd7,         32'h0000_000E, 1'b0);
    do_op("div_by0",     1'b0, 32'd5,          32'd0,         32'h0000_0000, 1'b1);
    do_op("div_min/-1",  1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    do_op("div_min/2",   1'b0, 32'h8000_0000,  32'd2,         32'hC000_0000, 1'b0);

    // divide start at t+5 of a multiply must be ignored, operands changed too
    @(negedge clock);
    issue(1'b1, 32'd7, 32'hFFFF_FFFD);
    repeat (4) @(negedge clock);
    data_operandA = 32'd100;
    data_operandB = 32'd7;
    ctrl_DIV      = 1'b1;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    wait_done(6, lat, bb);
    finish_checks("mul_ignore_div", lat, bb, 33, 32'hFFFF_FFEB, 1'b0);

    // back-to-back multiply accepted in the RDY cycle
    issue(1'b1, 32'd6, 32'd7);
    wait_done(1, lat, bb);
    finish_checks("mul_b2b", lat, bb, 33, 32'd42, 1'b0);

    // asynchronous reset at t+10 of a divide
    @(negedge clock);
    issue(1'b0, 32'd100, 32'd7);
    repeat (9) @(negedge clock);
    #1 reset = 1'b1;
    #1;
    check("arst_res", data_result, 32'd0);
    check("arst_flags", {29'd0, data_exception, data_resultRDY, busy}, 32'd0);
    check("arst_alu", alu_operandA | alu_operandB | {27'd0, alu_opcode}, 32'd0);
    #1 reset = 1'b0;
    rdy_seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY || busy) rdy_seen++;
    end
    check("arst_no_rdy", 32'(rdy_seen), 32'd0);
    do_op("mul_3x4", 1'b1, 32'd3, 32'd4, 32'd12, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
